// File: rtl/qspi_bus_arbiter.sv
// qspi_bus_arbiter: arbitrates fetch and data requests onto the shared quad-SPI
// engine, decodes each address to flash or PSRAM, and enforces a chip-select
// deselect gap after every completed transaction.
module qspi_bus_arbiter #(
    parameter logic [31:0] FLASH_BASE_ADDR = 32'h00000000,
    parameter logic [31:0] PSRAM_BASE_ADDR = 32'h01000000,
    parameter int          CS_GAP_CYCLES   = 2,
    parameter int          STARVE_LIMIT    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic        if_err,
    input  logic        dm_req,
    input  logic [31:0] dm_addr,
    input  logic        dm_we,
    output logic        dm_gnt,
    output logic        dm_done,
    output logic        dm_err,
    output logic        eng_start,
    output logic [23:0] eng_addr,
    output logic        eng_we,
    output logic        eng_psram,
    input  logic        eng_done,
    output logic        busy
);

    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [3:0] GAP_LOAD = 4'(CS_GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE,
        S_GAP,
        S_ERR
    } state_t;

    state_t                r_state;
    logic                  r_owner;
    logic [3:0]            r_gapCnt;
    logic [STARVE_W-1:0]   r_starveCnt;

    state_t                w_nextState;
    logic                  w_nextOwner;
    logic [3:0]            w_nextGap;
    logic [STARVE_W-1:0]   w_nextStarve;
    logic [23:0]           w_nextAddr;
    logic                  w_nextWe;
    logic                  w_nextPsram;
    logic                  w_inGrant;

    logic                  w_dataWins;
    logic [31:0]           w_selAddr;
    logic                  w_selWe;
    logic                  w_flashHit;
    logic                  w_psramHit;
    logic                  w_illegal;

    // Data normally wins; fetch is forced once it has lost STARVE_LIMIT times in a row.
    assign w_dataWins = dm_req && !(if_req && (r_starveCnt == STARVE_MAX));
    assign w_selAddr  = w_dataWins ? dm_addr : if_addr;
    assign w_selWe    = w_dataWins && dm_we;
    assign w_flashHit = (w_selAddr[31:24] == FLASH_BASE_ADDR[31:24]);
    assign w_psramHit = (w_selAddr[31:24] == PSRAM_BASE_ADDR[31:24]);
    // Flash has priority on overlapping bases, so a write that hits flash is rejected.
    assign w_illegal  = !(w_flashHit || w_psramHit) || (w_selWe && w_flashHit);

    // FSM state and bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_gapCnt    <= 4'd0;
            r_starveCnt <= '0;
        end else begin
            r_state     <= w_nextState;
            r_owner     <= w_nextOwner;
            r_gapCnt    <= w_nextGap;
            r_starveCnt <= w_nextStarve;
        end
    end

    // Next-state, arbitration decision and latched command for the engine.
    always_comb begin
        w_nextState  = r_state;
        w_nextOwner  = r_owner;
        w_nextGap    = r_gapCnt;
        w_nextStarve = r_starveCnt;
        w_nextAddr   = eng_addr;
        w_nextWe     = eng_we;
        w_nextPsram  = eng_psram;

        case (r_state)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    w_nextOwner = w_dataWins;
                    w_nextAddr  = w_selAddr[23:0];
                    w_nextWe    = w_selWe;
                    w_nextPsram = !w_flashHit && w_psramHit;
                    if (w_dataWins && if_req) begin
                        w_nextStarve = (r_starveCnt == STARVE_MAX) ? r_starveCnt
                                                                   : r_starveCnt + 1'b1;
                    end else begin
                        w_nextStarve = '0;
                    end
                    w_nextState = w_illegal ? S_ERR : S_START;
                end
            end
            S_START: begin
                w_nextState = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                if (CS_GAP_CYCLES > 0) begin
                    w_nextState = S_GAP;
                    w_nextGap   = GAP_LOAD;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gapCnt <= 4'd1) begin
                    w_nextState = S_IDLE;
                    w_nextGap   = 4'd0;
                end else begin
                    w_nextGap   = r_gapCnt - 4'd1;
                end
            end
            S_ERR: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase

        w_inGrant = (w_nextState == S_START) || (w_nextState == S_WAIT) ||
                    (w_nextState == S_DONE);
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_gnt    <= 1'b0;
            if_done   <= 1'b0;
            if_err    <= 1'b0;
            dm_gnt    <= 1'b0;
            dm_done   <= 1'b0;
            dm_err    <= 1'b0;
            eng_start <= 1'b0;
            eng_addr  <= 24'd0;
            eng_we    <= 1'b0;
            eng_psram <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if_gnt    <= w_inGrant && !w_nextOwner;
            dm_gnt    <= w_inGrant && w_nextOwner;
            if_done   <= ((w_nextState == S_DONE) || (w_nextState == S_ERR)) && !w_nextOwner;
            dm_done   <= ((w_nextState == S_DONE) || (w_nextState == S_ERR)) && w_nextOwner;
            if_err    <= (w_nextState == S_ERR) && !w_nextOwner;
            dm_err    <= (w_nextState == S_ERR) && w_nextOwner;
            eng_start <= (w_nextState == S_START);
            eng_addr  <= w_nextAddr;
            eng_we    <= w_nextWe;
            eng_psram <= w_nextPsram;
            busy      <= (w_nextState != S_IDLE);
        end
    end

endmodule
